// File: rtl/tlc_pkg.sv
// Shared definitions for the two-road traffic light controller:
// light encodings, sequencer phase enum and a small sizing helper.
package tlc_pkg;

  localparam logic [1:0] LIGHT_GREEN  = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_RED    = 2'b10;

  typedef enum logic [2:0] {
    AG = 3'd0,
    AY = 3'd1,
    BG = 3'd2,
    BY = 3'd3,
    WK = 3'd4
  } state_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Phase counter: cleared on request, otherwise counts up and holds at SAT_VAL.
module tlc_phase_timer #(
  parameter int CNT_W   = 5,
  parameter int SAT_VAL = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(SAT_VAL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != SAT) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tlc_sequencer.sv
// Timed phase sequencer for the two-road intersection with an optional
// all-red pedestrian walk phase after B-yellow.
module tlc_sequencer
  import tlc_pkg::*;
#(
  parameter int GREEN_MIN = 5,
  parameter int GREEN_MAX = 20,
  parameter int YELLOW_T  = 3,
  parameter int WALK_T    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ta,
  input  logic       tb,
  input  logic       ped_req,
  output logic [1:0] La,
  output logic [1:0] Lb,
  output logic       walk,
  output logic       ped_ack
);

  localparam int MAX_P = max_of(max_of(GREEN_MIN, GREEN_MAX), max_of(YELLOW_T, WALK_T));
  localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  localparam logic [CNT_W-1:0] GMIN_END = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_END = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] Y_END    = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] W_END    = CNT_W'(WALK_T - 1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             ped_pending;
  logic             phase_clr;
  logic             a_go;
  logic             b_go;
  logic             y_end;
  logic             w_end;

  tlc_phase_timer #(
    .CNT_W   (CNT_W),
    .SAT_VAL (GREEN_MAX - 1)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (phase_clr),
    .cnt   (cnt)
  );

  // A green ends early once the minimum is served and either the road is
  // empty or a pedestrian is waiting; the maximum always ends it.
  assign a_go  = ((cnt >= GMIN_END) && (!ta || ped_pending)) || (cnt == GMAX_END);
  assign b_go  = ((cnt >= GMIN_END) && (!tb || ped_pending)) || (cnt == GMAX_END);
  assign y_end = (cnt == Y_END);
  assign w_end = (cnt == W_END);

  always_comb begin
    state_nx = state;
    case (state)
      AG:      if (a_go)  state_nx = AY;
      AY:      if (y_end) state_nx = BG;
      BG:      if (b_go)  state_nx = BY;
      BY:      if (y_end) state_nx = ped_pending ? WK : AG;
      WK:      if (w_end) state_nx = AG;
      default: state_nx = AG;
    endcase
  end

  assign phase_clr = (state_nx != state);

  // Lights are registered from the next state, so they always match the
  // state register with no extra latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= AG;
      ped_pending <= 1'b0;
      La          <= LIGHT_GREEN;
      Lb          <= LIGHT_RED;
      walk        <= 1'b0;
      ped_ack     <= 1'b0;
    end else begin
      state <= state_nx;
      if ((state == BY) && (state_nx == WK)) begin
        ped_pending <= 1'b0;
      end else if (ped_req && (state != WK)) begin
        ped_pending <= 1'b1;
      end
      ped_ack <= (state_nx == WK) && (state != WK);
      walk    <= 1'b0;
      case (state_nx)
        AG: begin La <= LIGHT_GREEN;  Lb <= LIGHT_RED;    end
        AY: begin La <= LIGHT_YELLOW; Lb <= LIGHT_RED;    end
        BG: begin La <= LIGHT_RED;    Lb <= LIGHT_GREEN;  end
        BY: begin La <= LIGHT_RED;    Lb <= LIGHT_YELLOW; end
        WK: begin La <= LIGHT_RED;    Lb <= LIGHT_RED; walk <= 1'b1; end
        default: begin La <= LIGHT_GREEN; Lb <= LIGHT_RED; end
      endcase
    end
  end

endmodule

// File: tb/tb_tlc_sequencer.sv
// Scenario bench for tlc_sequencer with a phase-level reference model.
module tb_tlc_sequencer;

  localparam int GMIN = 4;
  localparam int GMAX = 10;
  localparam int YT   = 2;
  localparam int WT   = 6;

  localparam int P_AG = 0;
  localparam int P_AY = 1;
  localparam int P_BG = 2;
  localparam int P_BY = 3;
  localparam int P_WK = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ta = 1'b0;
  logic       tb = 1'b0;
  logic       ped_req = 1'b0;
  logic [1:0] La;
  logic [1:0] Lb;
  logic       walk;
  logic       ped_ack;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  tlc_sequencer #(
    .GREEN_MIN (GMIN),
    .GREEN_MAX (GMAX),
    .YELLOW_T  (YT),
    .WALK_T    (WT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ta      (ta),
    .tb      (tb),
    .ped_req (ped_req),
    .La      (La),
    .Lb      (Lb),
    .walk    (walk),
    .ped_ack (ped_ack)
  );

  // Expected {La, Lb, walk, ped_ack} for a phase
  function automatic logic [5:0] code(input int ph, input logic ack);
    case (ph)
      P_AG:    return {2'b00, 2'b10, 1'b0, ack};
      P_AY:    return {2'b01, 2'b10, 1'b0, ack};
      P_BG:    return {2'b10, 2'b00, 1'b0, ack};
      P_BY:    return {2'b10, 2'b01, 1'b0, ack};
      default: return {2'b10, 2'b10, 1'b1, ack};
    endcase
  endfunction

  function automatic void add(input int ph, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(ph);
  endfunction

  // Reference model: phase index, cycles elapsed in phase, pending request
  int   m_ph;
  int   m_el;
  int   m_len;
  int   m_nx;
  logic m_pend;
  logic m_ack;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ph = P_AG; m_el = 0; m_pend = 1'b0; m_ack = 1'b0;
    end else begin
      m_len = m_el + 1;
      m_nx  = m_ph;
      case (m_ph)
        P_AG: if ((m_len >= GMIN && (!ta || m_pend)) || m_len >= GMAX) m_nx = P_AY;
        P_AY: if (m_len == YT) m_nx = P_BG;
        P_BG: if ((m_len >= GMIN && (!tb || m_pend)) || m_len >= GMAX) m_nx = P_BY;
        P_BY: if (m_len == YT) m_nx = m_pend ? P_WK : P_AG;
        default: if (m_len == WT) m_nx = P_AG;
      endcase
      if (m_ph == P_BY && m_nx == P_WK) m_pend = 1'b0;
      else if (ped_req && m_ph != P_WK) m_pend = 1'b1;
      m_ack = (m_nx == P_WK) && (m_ph != P_WK);
      m_el  = (m_nx != m_ph) ? 0 : m_el + 1;
      m_ph  = m_nx;
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    ped_req = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({La, Lb, walk, ped_ack} !== code(P_AG, 1'b0)) begin
      n_err++;
      $display("FAIL reset_outputs got %b exp %b", {La, Lb, walk, ped_ack}, code(P_AG, 1'b0));
    end
    n_cmp++;
    if (dut.ped_pending !== 1'b0) begin
      n_err++;
      $display("FAIL reset_pending got %b exp 0", dut.ped_pending);
    end
    do_reset();
  endtask

  task automatic test_no_traffic;
    int prev;
    do_reset();
    ta = 1'b0; tb = 1'b0;
    exp_q.delete();
    add(P_AG, 4); add(P_AY, 2); add(P_BG, 4); add(P_BY, 2);
    add(P_AG, 4); add(P_AY, 2); add(P_BG, 4); add(P_BY, 2); add(P_AG, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      prev = (i == 0) ? P_AG : exp_q[i-1];
      n_cmp++;
      if ({La, Lb, walk, ped_ack} !== code(exp_q[i], exp_q[i] == P_WK && prev != P_WK)) begin
        n_err++;
        $display("FAIL no_traffic[%0d] got %b exp %b", i, {La, Lb, walk, ped_ack},
                 code(exp_q[i], exp_q[i] == P_WK && prev != P_WK));
      end
      tick();
    end
  endtask

  task automatic test_max_cap;
    int n;
    do_reset();
    ta = 1'b1; tb = 1'b1;
    n = 0;
    while (La === 2'b00 && n < GMAX + 5) begin
      n++;
      tick();
    end
    n_cmp++;
    if (n != GMAX) begin
      n_err++;
      $display("FAIL max_cap_len got %0d exp %0d", n, GMAX);
    end
    n_cmp++;
    if (La !== 2'b01) begin
      n_err++;
      $display("FAIL max_cap_next got %b exp 01", La);
    end
  endtask

  task automatic test_ped_walk;
    int prev;
    do_reset();
    ta = 1'b1; tb = 1'b0;
    exp_q.delete();
    add(P_AG, 4); add(P_AY, 2); add(P_BG, 4); add(P_BY, 2); add(P_WK, 6); add(P_AG, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      prev = (i == 0) ? P_AG : exp_q[i-1];
      n_cmp++;
      if ({La, Lb, walk, ped_ack} !== code(exp_q[i], exp_q[i] == P_WK && prev != P_WK)) begin
        n_err++;
        $display("FAIL ped_walk[%0d] got %b exp %b", i, {La, Lb, walk, ped_ack},
                 code(exp_q[i], exp_q[i] == P_WK && prev != P_WK));
      end
      ped_req = (i == 1);
      tick();
    end
    ped_req = 1'b0;
  endtask

  // Second request lands either on the last BY cycle or inside WK;
  // neither may produce a WALK in the following round.
  task automatic test_ped_repeat(input int idx2, input string name);
    int prev;
    do_reset();
    ta = 1'b0; tb = 1'b0;
    exp_q.delete();
    add(P_AG, 4); add(P_AY, 2); add(P_BG, 4); add(P_BY, 2); add(P_WK, 6);
    add(P_AG, 4); add(P_AY, 2); add(P_BG, 4); add(P_BY, 2); add(P_AG, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      prev = (i == 0) ? P_AG : exp_q[i-1];
      n_cmp++;
      if ({La, Lb, walk, ped_ack} !== code(exp_q[i], exp_q[i] == P_WK && prev != P_WK)) begin
        n_err++;
        $display("FAIL %s[%0d] got %b exp %b", name, i, {La, Lb, walk, ped_ack},
                 code(exp_q[i], exp_q[i] == P_WK && prev != P_WK));
      end
      if (i == 12 || i == 29) begin
        n_cmp++;
        if (dut.ped_pending !== 1'b0) begin
          n_err++;
          $display("FAIL %s_pending[%0d] got %b exp 0", name, i, dut.ped_pending);
        end
      end
      ped_req = (i == 1) || (i == idx2);
      tick();
    end
    ped_req = 1'b0;
  endtask

  task automatic test_async_reset;
    int n;
    do_reset();
    ta = 1'b0; tb = 1'b0;
    repeat (9) tick();
    n_cmp++;
    if ({La, Lb} !== 4'b1000) begin
      n_err++;
      $display("FAIL async_pre got %b exp 1000", {La, Lb});
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({La, Lb, walk, ped_ack} !== code(P_AG, 1'b0)) begin
      n_err++;
      $display("FAIL async_reset got %b exp %b", {La, Lb, walk, ped_ack}, code(P_AG, 1'b0));
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (La === 2'b00 && n < 20) begin
      n++;
      tick();
    end
    n_cmp++;
    if (n != GMIN) begin
      n_err++;
      $display("FAIL async_ag_len got %0d exp %0d", n, GMIN);
    end
  endtask

  task automatic test_random;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      n_cmp++;
      if ({La, Lb, walk, ped_ack} !== code(m_ph, m_ack)) begin
        n_err++;
        $display("FAIL random_model[%0d] got %b exp %b", i, {La, Lb, walk, ped_ack}, code(m_ph, m_ack));
      end
      n_cmp++;
      if (La !== 2'b10 && Lb !== 2'b10) begin
        n_err++;
        $display("FAIL random_conflict[%0d] got La=%b Lb=%b exp one red", i, La, Lb);
      end
      n_cmp++;
      if (walk === 1'b1 && !(La === 2'b10 && Lb === 2'b10)) begin
        n_err++;
        $display("FAIL random_walk[%0d] got La=%b Lb=%b exp both 10", i, La, Lb);
      end
      ta      = 1'($urandom_range(0, 1));
      tb      = 1'($urandom_range(0, 1));
      ped_req = ($urandom_range(0, 7) == 0);
      tick();
    end
    ped_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout reached exp completion");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    do_reset();
    test_reset();
    test_no_traffic();
    test_max_cap();
    test_ped_walk();
    test_ped_repeat(11, "ped_last_by");
    test_ped_repeat(14, "ped_in_wk");
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
